// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// ----------------
// Immediate decoder sitting between instruction fetch and register read.
// Each instruction's immediate format is classified from its opcode, or
// forced by an external override code. The immediate is sign-extended to
// XLEN bits. The result is carried through a registered valid/ready stage
// that has a two-entry skid buffer.
//
// Parameters:
//   XLEN      datapath width, 32 or 64
//   RV64_OPS  with XLEN=64, also decode OP-IMM-32 / OP-32
//
// Ports:
//   clk              single clock, rising edge
//   reset            synchronous, active-high reset
//   in_valid         upstream instruction valid
//   in_ready         stage can accept an instruction this cycle
//   in_instr         raw 32-bit instruction word
//   src_override_en  use src_override instead of the opcode decode
//   src_override     forced format code
//   out_valid        output fields are valid
//   out_ready        consumer accepts this cycle
//   out_imm          sign-extended immediate (XLEN bits)
//   out_fmt          I=000 S=001 B=010 J=011 U=100 NONE=111
//   out_illegal      unknown opcode or illegal override code
//   out_instr        instruction passed through unchanged

module imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter int RV64_OPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            src_override_en,
  input  logic [2:0]      src_override,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_NONE = 3'b111;

  localparam bit RV64_EN = (XLEN == 64) && (RV64_OPS != 0);

  // A stored entry is {instr, illegal, fmt, imm}.
  localparam int ENTRY_W = XLEN + 36;
  localparam logic [ENTRY_W-1:0] ENTRY_RESET = {32'd0, 1'b0, FMT_NONE, {XLEN{1'b0}}};

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic                 r_inReady;
  logic [ENTRY_W-1:0]   r_mEntry;
  logic [ENTRY_W-1:0]   r_kEntry;

  logic [2:0]           w_fmt;
  logic                 w_illegal;
  logic [XLEN-1:0]      w_imm;
  logic [ENTRY_W-1:0]   w_newEntry;
  logic                 w_inFire;
  logic                 w_outFire;
  logic                 w_loadM;
  logic                 w_loadK;
  logic                 w_moveK;

  // Format classification. The opcode decide the format, unless the
  // override is enabled. Override codes 101 and 110 have no format, so they
  // are flagged illegal. Every other override code is trusted as given.
  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011,
      7'b0000011,
      7'b1100111,
      7'b1110011: w_fmt = FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b1101111: w_fmt = FMT_J;
      7'b0110111,
      7'b0010111: w_fmt = FMT_U;
      7'b0110011: w_fmt = FMT_NONE;
      7'b0011011: begin
        if (RV64_EN) begin
          w_fmt = FMT_I;
        end else begin
          w_illegal = 1'b1;
        end
      end
      7'b0111011: begin
        if (!RV64_EN) begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (src_override_en) begin
      if ((src_override == 3'b101) || (src_override == 3'b110)) begin
        w_fmt     = FMT_NONE;
        w_illegal = 1'b1;
      end else begin
        w_fmt     = src_override;
        w_illegal = 1'b0;
      end
    end
  end

  // Immediate assembly. Bit 31 of the instruction fills every upper bit.
  // For U, the upper bits are filled first, and then the low 32 bits are
  // overwritten. This keeps the XLEN=32 case free of a zero-width replication.
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I: w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      FMT_S: w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
      FMT_J: w_imm = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
      FMT_U: begin
        w_imm       = {XLEN{in_instr[31]}};
        w_imm[31:0] = {in_instr[31:12], 12'd0};
      end
      default: w_imm = '0;
    endcase
  end

  assign w_newEntry = {in_instr, w_illegal, w_fmt, w_imm};

  assign w_inFire  = in_valid & in_ready;
  assign w_outFire = out_valid & out_ready;

  // Skid-buffer control. M always holds the oldest instruction. K is used
  // only when M is still waiting and a new instruction arrives. No input is
  // accepted while FULL, so that case only ever has to drain K into M.
  always_comb begin
    w_stateNext = r_state;
    w_loadM     = 1'b0;
    w_loadK     = 1'b0;
    w_moveK     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_inFire) begin
          w_stateNext = ONE;
          w_loadM     = 1'b1;
        end
      end
      ONE: begin
        if (w_inFire && w_outFire) begin
          w_loadM = 1'b1;
        end else if (w_inFire) begin
          w_stateNext = FULL;
          w_loadK     = 1'b1;
        end else if (w_outFire) begin
          w_stateNext = EMPTY;
        end
      end
      FULL: begin
        if (w_outFire) begin
          w_stateNext = ONE;
          w_moveK     = 1'b1;
        end
      end
      default: w_stateNext = EMPTY;
    endcase
  end

  // State and storage registers. r_inReady is precomputed from the next
  // state, so in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_inReady <= 1'b1;
      r_mEntry  <= ENTRY_RESET;
      r_kEntry  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_inReady <= (w_stateNext != FULL);
      if (w_loadM) begin
        r_mEntry <= w_newEntry;
      end else if (w_moveK) begin
        r_mEntry <= r_kEntry;
      end
      if (w_loadK) begin
        r_kEntry <= w_newEntry;
      end
    end
  end

  // in_ready is masked during reset, so nothing is taken in a reset cycle.
  assign in_ready  = r_inReady & ~reset;
  assign out_valid = (r_state != EMPTY);
  assign {out_instr, out_illegal, out_fmt, out_imm} = r_mEntry;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
// -------------------
// Scoreboard bench for imm_decode_stage. It instantiates an XLEN=32 and an
// XLEN=64 copy, and drives both from the same inputs. Expected responses
// are hand-computed constants. They are queued when an instruction is
// accepted, and a separate monitor checks them when the DUTs emit.

module tb_imm_decode_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        src_override_en;
  logic [2:0]  src_override;
  logic        out_ready;

  logic        inReady32, outValid32, outIllegal32;
  logic [31:0] outImm32, outInstr32;
  logic [2:0]  outFmt32;
  logic        inReady64, outValid64, outIllegal64;
  logic [63:0] outImm64;
  logic [31:0] outInstr64;
  logic [2:0]  outFmt64;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
    int          acc;
    bit          chkLat;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  localparam int NV = 17;
  // Columns: instr, override enable/code, XLEN=64 expectations, XLEN=32 expectations.
  logic [31:0] vInstr [NV] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h001000EF,
                               32'h800002B7, 32'h0000001B, 32'hFFF00093, 32'hFFF00093,
                               32'h00000033, 32'h0000007F, 32'h0000003B, 32'hFFF00093,
                               32'h7FF00013, 32'h00001237, 32'hFFF00093, 32'hFFF00093,
                               32'hFFF00093};
  logic        vOvEn  [NV] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1};
  logic [2:0]  vOv    [NV] = '{0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 7, 0, 0, 6, 3, 2};
  logic [63:0] vImm64 [NV] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC,
                               64'hFFFFFFFF_FFFFFFF8, 64'h00000000_00000800,
                               64'hFFFFFFFF_80000000, 64'h0,
                               64'hFFFFFFFF_FFFFFFE1, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                               64'h00000000_000007FF, 64'h00000000_00001000, 64'h0,
                               64'hFFFFFFFF_FFF00FFE, 64'hFFFFFFFF_FFFFFFE0};
  logic [2:0]  vFmt64 [NV] = '{0, 1, 2, 3, 4, 0, 1, 7, 7, 7, 7, 7, 0, 4, 7, 3, 2};
  logic        vIll64 [NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  logic [63:0] vImm32 [NV] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h00000800,
                               64'h80000000, 64'h0, 64'hFFFFFFE1, 64'h0, 64'h0, 64'h0,
                               64'h0, 64'h0, 64'h000007FF, 64'h00001000, 64'h0,
                               64'hFFF00FFE, 64'hFFFFFFE0};
  logic [2:0]  vFmt32 [NV] = '{0, 1, 2, 3, 4, 7, 1, 7, 7, 7, 7, 7, 0, 4, 7, 3, 2};
  logic        vIll32 [NV] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0};

  imm_decode_stage #(.XLEN(32), .RV64_OPS(1)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady32),
    .in_instr(in_instr), .src_override_en(src_override_en), .src_override(src_override),
    .out_valid(outValid32), .out_ready(out_ready), .out_imm(outImm32), .out_fmt(outFmt32),
    .out_illegal(outIllegal32), .out_instr(outInstr32)
  );

  imm_decode_stage #(.XLEN(64), .RV64_OPS(1)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady64),
    .in_instr(in_instr), .src_override_en(src_override_en), .src_override(src_override),
    .out_valid(outValid64), .out_ready(out_ready), .out_imm(outImm64), .out_fmt(outFmt64),
    .out_illegal(outIllegal64), .out_instr(outInstr64)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, used to check the one-cycle acceptance-to-output latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one value, count it, and report a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Place vector idx on the input pins without asserting valid.
  task automatic setInputs(input int idx);
    in_instr        = vInstr[idx];
    src_override_en = vOvEn[idx];
    src_override    = vOv[idx];
  endtask

  // Offer vector idx until both copies accept it, and queue the expected
  // responses. The task returns just after the accepting edge, with in_valid
  // still high, so that calls made back to back stream one instruction per cycle.
  task automatic applyStimulus(input int idx, input bit lat);
    int   waited;
    bit   accepted;
    exp_t e;
    setInputs(idx);
    in_valid = 1'b1;
    waited   = 0;
    accepted = 0;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (inReady32 && inReady64) begin
        accepted = 1;
        e.instr  = vInstr[idx];
        e.acc    = cyc;
        e.chkLat = lat;
        e.imm = vImm32[idx]; e.fmt = vFmt32[idx]; e.ill = vIll32[idx];
        q32.push_back(e);
        e.imm = vImm64[idx]; e.fmt = vFmt64[idx]; e.ill = vIll64[idx];
        q64.push_back(e);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL acceptTimeout actual=0 expected=1 (vector %0d)", idx);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Wait, with a bound, until every queued expectation has been consumed.
  task automatic drain();
    int waited;
    waited = 0;
    while ((q32.size() != 0 || q64.size() != 0) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    checkOutput("drainEmpty", 64'(q32.size() + q64.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every mid-cycle sample where a DUT transfers an output, pop
  // the oldest expectation and compare all fields and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && outValid32 && out_ready) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedOut32 actual=%0h expected=none", outInstr32);
      end else begin
        e = q32.pop_front();
        checkOutput("imm32",   {32'd0, outImm32}, e.imm);
        checkOutput("fmt32",   64'(outFmt32), 64'(e.fmt));
        checkOutput("ill32",   64'(outIllegal32), 64'(e.ill));
        checkOutput("instr32", 64'(outInstr32), 64'(e.instr));
        if (e.chkLat) checkOutput("latency32", 64'(cyc), 64'(e.acc + 1));
      end
    end
    if (!reset && outValid64 && out_ready) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedOut64 actual=%0h expected=none", outInstr64);
      end else begin
        e = q64.pop_front();
        checkOutput("imm64",   outImm64, e.imm);
        checkOutput("fmt64",   64'(outFmt64), 64'(e.fmt));
        checkOutput("ill64",   64'(outIllegal64), 64'(e.ill));
        checkOutput("instr64", 64'(outInstr64), 64'(e.instr));
        if (e.chkLat) checkOutput("latency64", 64'(cyc), 64'(e.acc + 1));
      end
    end
  end

  // Check that both copies show their reset values.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "Valid32"}, 64'(outValid32), 64'd0);
    checkOutput({tag, "Valid64"}, 64'(outValid64), 64'd0);
    checkOutput({tag, "InReady"}, 64'(inReady32 | inReady64), 64'd0);
    checkOutput({tag, "Imm64"},   outImm64, 64'd0);
    checkOutput({tag, "Imm32"},   64'(outImm32), 64'd0);
    checkOutput({tag, "Fmt"},     64'(outFmt64), 64'd7);
    checkOutput({tag, "Ill"},     64'(outIllegal64 | outIllegal32), 64'd0);
    checkOutput({tag, "Instr"},   64'(outInstr64), 64'd0);
  endtask

  // Main sequence: reset, streaming, stall, then reset while FULL.
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    src_override_en = 1'b0; src_override = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", 64'(inReady32 & inReady64), 64'd1);
    @(posedge clk); #1;

    // Streaming, with every vector back to back and the output always ready.
    for (int i = 0; i < NV; i++) applyStimulus(i, 1'b1);
    idle();
    drain();

    // Stall: A and B fill M and K, and C must be held until the release.
    out_ready = 1'b0;
    applyStimulus(12, 1'b0);
    applyStimulus(1, 1'b0);
    setInputs(4);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallInReady", 64'(inReady32 | inReady64), 64'd0);
      checkOutput("stallValid",   64'(outValid64), 64'd1);
      checkOutput("stallHold",    64'(outInstr64), 64'h7FF00013);
      checkOutput("stallHoldImm", outImm64, 64'h7FF);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(4, 1'b0);
    idle();
    drain();

    // Reset while FULL. The pending D and E are discarded, and F, offered
    // during reset, must never appear.
    out_ready = 1'b0;
    applyStimulus(0, 1'b0);
    applyStimulus(2, 1'b0);
    setInputs(3);
    in_valid = 1'b1;
    reset    = 1'b1;
    q32.delete();
    q64.delete();
    @(negedge clk);
    checkOutput("resetCycleInReady", 64'(inReady32 | inReady64), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkResetState("midRst");
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterMidReset", 64'(inReady32 & inReady64), 64'd1);
    checkOutput("validAfterMidReset", 64'(outValid32 | outValid64), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(13, 1'b1);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog, so that a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Pipelined, parametrised immediate decoder for the RISC-V core, placed between instruction fetch and the register-read/execute stage. Classifies each instruction's immediate format from its opcode, with an optional external format override, and sign-extends the immediate to XLEN bits. Carries the result through a registered valid/ready stage with a two-entry skid buffer, so a stalled downstream never drops or duplicates an instruction. Also flags opcodes that have no legal encoding.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 and 64 only.
- RV64_OPS, 1: when XLEN=64, also decode OP-IMM-32 and OP-32; ignored when XLEN=32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction on `in_instr` is valid.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  raw instruction word.
- src_override_en  input  1  when 1, use `src_override` instead of opcode decode.
- src_override  input  3  forced format code.
- out_valid  output  1  output fields are valid.
- out_ready  input  1  consumer accepts this cycle.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  format code: I=000, S=001, B=010, J=011, U=100, NONE=111.
- out_illegal  output  1  opcode not recognised, or override code not legal.
- out_instr  output  32  instruction passed through unchanged.

## Operation
- Opcode map (`instr[6:0]`):
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 0110011 → NONE, legal.
  - With XLEN=64 and RV64_OPS=1: 0011011 → I; 0111011 → NONE, legal.
  - Any other opcode → NONE with out_illegal=1.
- Override:
  - Legal override codes are 000–100 and 111. They set out_illegal=0, and the immediate uses that format.
  - Override codes 101 and 110 give fmt=NONE, imm=0, out_illegal=1.
- Immediate formation (s = `instr[31]` replicated to fill XLEN):
  - I: s, `instr[31:20]`.
  - S: s, `instr[31:25]`, `instr[11:7]`.
  - B: s, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0.
  - J: s, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0.
  - U: s, `instr[31:12]`, 12 zeros. For XLEN=64, bits 63:32 replicate `instr[31]`.
  - NONE: all zeros.
- Decode is combinational on the input side. Results are captured into a main output register (M) or a skid register (K).
- A transfer happens when valid and ready are both 1 in the same cycle.
- States:
  - EMPTY: M invalid, K invalid.
  - ONE: M valid, K invalid.
  - FULL: M valid, K valid.
- `in_ready` = not FULL. It is a registered signal and does not depend combinationally on `out_ready`.
- Transitions (in = input transfer, out = output transfer):
  - EMPTY: in → ONE (load M).
  - ONE:
    - in and out → ONE (M reloads with the new input).
    - in only → FULL (new input to K).
    - out only → EMPTY.
  - FULL: out → ONE (K moves to M). No input is accepted in FULL.
- Order is strictly FIFO. M always holds the oldest instruction.
- Output fields stay stable while out_valid=1 and out_ready=0.

## Timing
- Latency: an instruction accepted in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle while out_ready stays high.
- Reset (sampled at clk):
  - Next state is EMPTY.
  - Outputs: out_valid=0, out_imm=0, out_fmt=111, out_illegal=0, out_instr=0.
  - in_ready=0 during any cycle in which reset is sampled high; in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards M and K with no output transfer. An in_valid present in the reset cycle is not accepted.
- Back-pressure: in_ready falls one cycle after the cycle that fills K, so at most two instructions are ever stored.
- FULL with out_ready=1 and in_valid=1 in the same cycle: only the output transfer occurs (in_ready=0); the input must be held.

## Test plan
- Streaming, out_ready=1, XLEN=32, inputs in consecutive cycles:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 000.
  - 0xFE112E23 → imm 0xFFFFFFFC, fmt 001.
  - 0xFE000CE3 → imm 0xFFFFFFF8, fmt 010.
  - 0x001000EF → imm 0x00000800, fmt 011.
  - Each output appears one cycle after acceptance, in back-to-back cycles.
- XLEN=64: 0x800002B7 → imm 0xFFFFFFFF80000000, fmt 100. 0x0000001B (OP-IMM-32) → fmt 000, illegal 0. With XLEN=32, 0x0000001B → fmt 111, imm 0, illegal 1.
- Stall: hold out_ready=0 and offer three instructions A, B, C. Required: A and B accepted, in_ready=0 from the cycle after B is accepted, C held. Release out_ready: A, B, C emerge in order with no loss or duplicate.
- Override: in_instr 0xFFF00093 with src_override_en=1, src_override=001 → imm 0xFFFFFFE1, fmt 001. With src_override=101 → fmt 111, imm 0, illegal 1.
- Reset while FULL → out_valid=0 and in_ready=0 in the cycle after the reset edge, all outputs at reset values, in_ready=1 after deassertion. The next accepted instruction is the first one output.
